pwm_pulse_gen: RTL and testbench
================================

Name: pwm_pulse_gen

Overview:
- Downstream stage of the throttle-to-pulse-width lookup. Consumes the 12-bit pulse width in microseconds (idle 900, throttle range 1064..1864) and drives one ESC servo-style PWM pin.
- Generates fixed-period frames from the system clock through a microsecond prescaler.
- Latches the requested width only at frame boundaries, so every pulse is glitch-free.
- One instance per motor.

Parameters:
- CLK_HZ, 50000000: system clock frequency; CLK_HZ/1000000 must be an integer ≥2. DIV = CLK_HZ/1000000.
- PWM_LEN, 12: width of the pulse-time input, in bits.
- FRAME_US, 20000: frame period in µs (50 Hz).
- FRAME_W, 15: microsecond counter width; 2^FRAME_W must be > FRAME_US.
- MIN_US, 900: lower clamp in µs.
- MAX_US, 2000: upper clamp in µs; MAX_US < FRAME_US.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: run request.
- pwm_signal_time, input, PWM_LEN: requested pulse width in µs.
- pwm_out, output, 1: pulse to the ESC.
- frame_start, output, 1: one-cycle strobe on the first cycle of each frame.
- busy, output, 1: high while a frame is in progress.
- latched_time, output, PWM_LEN: clamped width in use for the current frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pwm_out=0, frame_start=0, busy=0, latched_time=0.
  - Prescaler and µs counter = 0.
  - Takes effect immediately, without a clock edge, including mid-pulse.
- States: IDLE, HIGH, LOW. pwm_out is 1 only in HIGH and is registered. busy=1 in HIGH or LOW.
- Prescaler counts 0..DIV-1 and wraps. us_tick is asserted on the cycle where the prescaler equals DIV-1. The prescaler and us_tick are active only outside IDLE.
- µs counter increments on us_tick.
- IDLE → HIGH on the edge where enable=1. On that edge:
  - latched_time <= clamp(pwm_signal_time).
  - Prescaler=0, µs counter=0.
  - pwm_out=1, frame_start=1 (for one cycle).
  - Output latency: one clock from enable sampled high to pwm_out high.
- clamp(x): MIN_US if x<MIN_US; MAX_US if x>MAX_US; otherwise x. Comparisons are unsigned.
- HIGH → LOW on the us_tick edge where µs counter+1 == latched_time. pwm_out is high for exactly latched_time*DIV clock cycles.
- LOW, end of frame: on the us_tick edge where the µs counter == FRAME_US-1:
  - If enable=1: restart the frame exactly as for IDLE → HIGH (relatch, frame_start, pwm_out=1, counters cleared).
  - If enable=0: go to IDLE; busy=0.
- Frame period is exactly FRAME_US*DIV cycles, back-to-back, with no gap cycles.
- pwm_signal_time changes mid-frame are ignored until the next frame boundary.
- enable deasserted mid-frame: the current frame completes in full (no truncated pulse), then the block goes to IDLE.
- enable reasserted in the same cycle as the end of frame: the frame continues seamlessly.
- Counter arithmetic: µs counter is FRAME_W bits and never exceeds FRAME_US-1. latched_time is zero-extended for comparison.

Test Plan (CLK_HZ=4000000 so DIV=4; FRAME_US=2500; other parameters default):
1. Hold reset=0 for 10 cycles, then release with enable=0 -> pwm_out=0, busy=0, frame_start=0 for 1000 cycles; latched_time=0.
2. enable=1, pwm_signal_time=1064 -> frame_start pulses once; pwm_out high for 4256 cycles then low; next frame_start arrives 10000 cycles after the first; latched_time=1064.
3. Clamp: input 900 -> high 3600 cycles; input 2500 -> latched 2000, high 8000 cycles; input 500 -> latched 900, high 3600 cycles.
4. Width 1064; change input to 1864 at cycle 1000 of the pulse -> current pulse stays 4256 cycles; following frame pulse is 7456 cycles.
5. Deassert enable at cycle 5000 of a frame -> frame finishes at cycle 10000, then pwm_out=0 and busy=0 with no further frame_start. Reassert enable -> pwm_out high one cycle later.
6. Assert reset=0 asynchronously between clock edges during HIGH -> pwm_out=0 and busy=0 before the next edge. After release with enable=1, a new frame starts with frame_start.

Source files
------------

// File: rtl/pwm_pulse_gen_if.sv
// pwm_pulse_gen_if: throttle width request in, ESC pulse and frame status out
interface pwm_pulse_gen_if #(parameter int PWM_LEN = 12) ();
  logic               enable;
  logic [PWM_LEN-1:0] pwm_signal_time;
  logic               pwm_out;
  logic               frame_start;
  logic               busy;
  logic [PWM_LEN-1:0] latched_time;
  modport master (output enable, pwm_signal_time, input pwm_out, frame_start, busy, latched_time);
  modport slave (input enable, pwm_signal_time, output pwm_out, frame_start, busy, latched_time);
endinterface

// File: rtl/pwm_pulse_gen.sv
// pwm_pulse_gen: fixed-period servo-style PWM frames with the width latched at each frame boundary
module pwm_pulse_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int PWM_LEN  = 12,
  parameter int FRAME_US = 20000,
  parameter int FRAME_W  = 15,
  parameter int MIN_US   = 900,
  parameter int MAX_US   = 2000
) (
  input logic            clock,
  input logic            reset,
  pwm_pulse_gen_if.slave bus
);
  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t             state_q, state_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [FRAME_W-1:0] us_q, us_d;
  logic [PWM_LEN-1:0] lat_q, lat_d, clamped;
  logic               pwm_q, pwm_d, fs_q, fs_d;
  logic               tick, frame_end, start;
  assign clamped = bus.pwm_signal_time < PWM_LEN'(MIN_US) ? PWM_LEN'(MIN_US)
                 : bus.pwm_signal_time > PWM_LEN'(MAX_US) ? PWM_LEN'(MAX_US)
                 : bus.pwm_signal_time;
  assign tick      = state_q != IDLE && pre_q == PW'(DIV - 1);
  assign frame_end = tick && state_q == LOW && us_q == FRAME_W'(FRAME_US - 1);
  // A frame restarts either from idle or seamlessly at the end of a running frame
  assign start     = bus.enable && (state_q == IDLE || frame_end);
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pwm_d   = pwm_q;
    fs_d    = 1'b0;
    pre_d   = (state_q == IDLE || tick) ? '0 : pre_q + 1'b1;
    us_d    = tick ? us_q + 1'b1 : us_q;
    if (start) begin
      state_d = HIGH;
      lat_d   = clamped;
      pre_d   = '0;
      us_d    = '0;
      pwm_d   = 1'b1;
      fs_d    = 1'b1;
    end else if (frame_end) begin
      state_d = IDLE;
      us_d    = '0;
      pwm_d   = 1'b0;
    end else if (state_q == HIGH && tick && us_q + 1'b1 == FRAME_W'(lat_q)) begin
      state_d = LOW;
      pwm_d   = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      us_q    <= '0;
      lat_q   <= '0;
      pwm_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      us_q    <= us_d;
      lat_q   <= lat_d;
      pwm_q   <= pwm_d;
      fs_q    <= fs_d;
    end
  end
  assign bus.pwm_out      = pwm_q;
  assign bus.frame_start  = fs_q;
  assign bus.busy         = state_q != IDLE;
  assign bus.latched_time = lat_q;
endmodule

// File: tb/tb_pwm_pulse_gen.sv
// tb_pwm_pulse_gen: directed checks of pulse width, frame period, clamping, enable and async reset
module tb_pwm_pulse_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n, fsn, t0, t1, t2, t3, bad;
  int vin[3]  = '{900, 2500, 500};
  int vlat[3] = '{900, 2000, 900};
  int vhi[3]  = '{3600, 8000, 3600};
  pwm_pulse_gen_if #(.PWM_LEN(12)) bus ();
  pwm_pulse_gen #(.CLK_HZ(4000000), .FRAME_US(2500)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic meas_high(output int cnt, output int fcnt);
    cnt = 0;
    fcnt = 0;
    while (bus.pwm_out === 1'b1 && cnt < 20000) begin
      cnt++;
      fcnt += int'(bus.frame_start);
      @(negedge clk);
    end
  endtask
  task automatic wait_fs(output int t);
    t = -100000;
    for (int k = 0; k < 12000; k++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.pwm_signal_time = '0;
    #1 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_pwm", bus.pwm_out, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      bad += int'(bus.pwm_out !== 1'b0 || bus.busy !== 1'b0 || bus.frame_start !== 1'b0);
    end
    chk("idle_outputs", bad, 0);
    chk("idle_latched", bus.latched_time, 0);
    bus.pwm_signal_time = 1064;
    bus.enable = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("start_fs", bus.frame_start, 1);
    chk("start_pwm", bus.pwm_out, 1);
    chk("start_busy", bus.busy, 1);
    chk("lat_1064", bus.latched_time, 1064);
    meas_high(n, fsn);
    chk("high_1064", n, 4256);
    chk("fs_once", fsn, 1);
    wait_fs(t1);
    chk("period", t1 - t0, 10000);
    repeat (1000) @(negedge clk);
    bus.pwm_signal_time = 1864;
    meas_high(n, fsn);
    chk("high_kept", 1000 + n, 4256);
    chk("lat_kept", bus.latched_time, 1064);
    wait_fs(t2);
    chk("period2", t2 - t1, 10000);
    chk("lat_1864", bus.latched_time, 1864);
    bus.pwm_signal_time = 1064;
    meas_high(n, fsn);
    chk("high_1864", n, 7456);
    wait_fs(t3);
    chk("period3", t3 - t2, 10000);
    repeat (5000) @(negedge clk);
    bus.enable = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
    end
    chk("frame_complete", cyc - t3, 10000);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      bad += int'(bus.pwm_out !== 1'b0 || bus.busy !== 1'b0 || bus.frame_start !== 1'b0);
    end
    chk("stopped", bad, 0);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("reenable_pwm", bus.pwm_out, 1);
    chk("reenable_fs", bus.frame_start, 1);
    repeat (100) @(negedge clk);
    chk("pre_rst_pwm", bus.pwm_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pwm", bus.pwm_out, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_lat", bus.latched_time, 0);
    for (int i = 0; i < 3; i++) begin
      rst_n = 1'b0;
      bus.pwm_signal_time = 12'(vin[i]);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("clamp_fs", bus.frame_start, 1);
      chk("clamp_lat", bus.latched_time, vlat[i]);
      meas_high(n, fsn);
      chk("clamp_high", n, vhi[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
